flash_rd_ctrl: RTL and testbench

FLASH_RD_CTRL -- requirements
Module: flash_rd_ctrl

---
 rtl/flash_rd_ctrl.sv | 129 ++++++++++++
 tb/tb_flash_rd_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/flash_rd_ctrl.sv
// flash_rd_ctrl: single-byte read controller for an asynchronous parallel flash.
// A request in IDLE latches the address and holds chip/output enable low for
// WAIT_CYC clocks. The flash data bus is then sampled into o_rdata, with a
// one-cycle o_valid pulse.
// Optional build macro FLASH_RD_CACHE_EN adds a one-entry read cache. A hit
// returns data one cycle after acceptance and does not touch the flash.
module flash_rd_ctrl #(
  parameter int unsigned WAIT_CYC = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [22:0] i_addr,
  output logic        o_busy,
  output logic        o_valid,
  output logic [7:0]  o_rdata,
  output logic [22:0] o_flash_addr,
  input  logic [7:0]  i_flash_q,
  output logic        o_flash_ce_n,
  output logic        o_flash_oe_n
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_valid;
  logic [7:0]  r_rdata;
  logic [22:0] r_flash_addr;

  logic        w_hit;
  logic [7:0]  w_hit_data;
  logic        w_accept;
  logic        w_done;

`ifdef FLASH_RD_CACHE_EN
  logic [22:0] r_cache_tag;
  logic [7:0]  r_cache_data;
  logic        r_cache_vld;

  assign w_hit      = (r_state == ST_IDLE) && i_req && r_cache_vld && (i_addr == r_cache_tag);
  assign w_hit_data = r_cache_data;

  // Cache entry follows every flash capture; reset invalidates it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cache_vld  <= 1'b0;
      r_cache_tag  <= '0;
      r_cache_data <= '0;
    end else if (w_done) begin
      r_cache_vld  <= 1'b1;
      r_cache_tag  <= r_flash_addr;
      r_cache_data <= i_flash_q;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  // A cache hit is served from IDLE, so it must not start a flash access
  assign w_accept = (r_state == ST_IDLE) && i_req && !w_hit;
  assign w_done   = (r_state == ST_WAIT) && (r_cnt == '0);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_done)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Flash strobes and busy decode directly from state
  always_comb begin
    o_busy       = 1'b0;
    o_flash_ce_n = 1'b1;
    o_flash_oe_n = 1'b1;
    if (r_state == ST_WAIT) begin
      o_busy       = 1'b1;
      o_flash_ce_n = 1'b0;
      o_flash_oe_n = 1'b0;
    end
  end

  // Datapath: address latch, access-time counter, read data and valid pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_flash_addr <= '0;
      r_rdata      <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= w_done || w_hit;
      if (w_accept) begin
        r_flash_addr <= i_addr;
        r_cnt        <= CNT_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        r_rdata <= i_flash_q;
      end else if (w_hit) begin
        r_rdata <= w_hit_data;
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_rdata      = r_rdata;
  assign o_flash_addr = r_flash_addr;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Directed bench for flash_rd_ctrl: instance A uses WAIT_CYC=7, instance B uses WAIT_CYC=1.
// The cache-hit expectations follow FLASH_RD_CACHE_EN in the same way as the RTL.
module tb_flash_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqA, reqB;
  logic [22:0] addrA, addrB;
  logic        busyA, busyB, validA, validB;
  logic [7:0]  rdataA, rdataB, qA, qB;
  logic [22:0] faddrA, faddrB;
  logic        ceA, ceB, oeA, oeB;
  logic        mem_alt;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [22:0] a, input logic alt);
    case (a)
      23'h000010: mem_rd = alt ? 8'h77 : 8'hA5;
      23'h400000: mem_rd = 8'h3C;
      23'h7FFFFF: mem_rd = 8'h5A;
      23'h000000: mem_rd = 8'h11;
      default:    mem_rd = a[7:0] ^ 8'hC3;
    endcase
  endfunction

  always_comb qA = mem_rd(faddrA, mem_alt);
  always_comb qB = mem_rd(faddrB, mem_alt);

  flash_rd_ctrl #(.WAIT_CYC(7)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(reqA), .i_addr(addrA),
    .o_busy(busyA), .o_valid(validA), .o_rdata(rdataA), .o_flash_addr(faddrA),
    .i_flash_q(qA), .o_flash_ce_n(ceA), .o_flash_oe_n(oeA)
  );

  flash_rd_ctrl #(.WAIT_CYC(1)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(reqB), .i_addr(addrB),
    .o_busy(busyB), .o_valid(validB), .o_rdata(rdataB), .o_flash_addr(faddrB),
    .i_flash_q(qB), .o_flash_ce_n(ceB), .o_flash_oe_n(oeB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; reqA = 1'b0; reqB = 1'b0; addrA = '0; addrB = '0; mem_alt = 1'b0;
    #1;
    // Reset state
    check("rst_busy",  32'(busyA),  32'd0);
    check("rst_valid", 32'(validA), 32'd0);
    check("rst_rdata", 32'(rdataA), 32'h00);
    check("rst_faddr", 32'(faddrA), 32'h0);
    check("rst_ce",    32'(ceA),    32'd1);
    check("rst_oe",    32'(oeA),    32'd1);
    check("rst_B_ce",  32'(ceB),    32'd1);
    tick; tick;
    rst_n = 1'b1;

    // Single read of 0x000010, accepted on the first edge after release
    reqA = 1'b1; addrA = 23'h000010;
    tick;
    reqA = 1'b0;
    check("rd1_busy",  32'(busyA),  32'd1);
    check("rd1_ce",    32'(ceA),    32'd0);
    check("rd1_oe",    32'(oeA),    32'd0);
    check("rd1_faddr", 32'(faddrA), 32'h10);
    for (int k = 1; k <= 6; k++) begin
      tick;
      check("rd1_ce_wait", 32'(ceA),    32'd0);
      check("rd1_nvalid",  32'(validA), 32'd0);
    end
    tick;
    check("rd1_valid",   32'(validA), 32'd1);
    check("rd1_rdata",   32'(rdataA), 32'hA5);
    check("rd1_idle_ce", 32'(ceA),    32'd1);
    check("rd1_idle_oe", 32'(oeA),    32'd1);
    check("rd1_idle",    32'(busyA),  32'd0);
    tick;
    check("rd1_vdrop",   32'(validA), 32'd0);
    check("rd1_hold",    32'(rdataA), 32'hA5);
    check("rd1_faddr_k", 32'(faddrA), 32'h10);

    // Short reset clears any cached entry, then back-to-back reads with i_req held high
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    reqA = 1'b1; addrA = 23'h000010;
    tick;
    check("b2b_faddr0", 32'(faddrA), 32'h10);
    addrA = 23'h400000;
    for (int i = 1; i <= 16; i++) begin
      tick;
      check("b2b_valid", 32'(validA), ((i == 7) || (i == 15)) ? 32'd1 : 32'd0);
      check("b2b_faddr", 32'(faddrA), (i < 8) ? 32'h10 : 32'h400000);
      if (i == 7)  check("b2b_data0", 32'(rdataA), 32'hA5);
      if (i == 15) check("b2b_data1", 32'(rdataA), 32'h3C);
      if (i == 8)  reqA = 1'b0;
    end

    // Address change during WAIT is ignored
    reqA = 1'b1; addrA = 23'h000010;
    tick;
    reqA = 1'b0; addrA = 23'h7FFFFF;
    for (int k = 1; k <= 6; k++) begin
      tick;
      check("ign_faddr", 32'(faddrA), 32'h10);
    end
    tick;
    check("ign_valid", 32'(validA), 32'd1);
    check("ign_rdata", 32'(rdataA), 32'hA5);
    check("ign_faddr_end", 32'(faddrA), 32'h10);
    tick;

    // Reset in the middle of an access
    reqA = 1'b1; addrA = 23'h400000;
    tick;
    reqA = 1'b0;
    tick; tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_ce",    32'(ceA),    32'd1);
    check("mrst_oe",    32'(oeA),    32'd1);
    check("mrst_busy",  32'(busyA),  32'd0);
    check("mrst_valid", 32'(validA), 32'd0);
    check("mrst_rdata", 32'(rdataA), 32'h00);
    check("mrst_faddr", 32'(faddrA), 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick;
      check("mrst_novalid", 32'(validA), 32'd0);
    end
    rst_n = 1'b1;
    reqA = 1'b1; addrA = 23'h000010;
    tick;
    reqA = 1'b0;
    check("post_busy", 32'(busyA), 32'd1);
    repeat (6) tick;
    tick;
    check("post_valid", 32'(validA), 32'd1);
    check("post_rdata", 32'(rdataA), 32'hA5);
    tick;

    // WAIT_CYC=1 instance: exactly one cycle with ce_n low
    reqB = 1'b1; addrB = 23'h000000;
    tick;
    reqB = 1'b0;
    check("w1_ce",    32'(ceB),    32'd0);
    check("w1_busy",  32'(busyB),  32'd1);
    check("w1_nval",  32'(validB), 32'd0);
    tick;
    check("w1_valid", 32'(validB), 32'd1);
    check("w1_rdata", 32'(rdataB), 32'h11);
    check("w1_ce_hi", 32'(ceB),    32'd1);
    tick;
    check("w1_vdrop", 32'(validB), 32'd0);

    // Repeat read of 0x000010 after the flash contents changed
    mem_alt = 1'b1;
    reqA = 1'b1; addrA = 23'h000010;
    tick;
    reqA = 1'b0;
`ifdef FLASH_RD_CACHE_EN
    check("hit_valid", 32'(validA), 32'd1);
    check("hit_rdata", 32'(rdataA), 32'hA5);
    check("hit_ce",    32'(ceA),    32'd1);
    check("hit_oe",    32'(oeA),    32'd1);
    check("hit_busy",  32'(busyA),  32'd0);
    tick;
    check("hit_vdrop", 32'(validA), 32'd0);
`else
    check("miss_busy", 32'(busyA), 32'd1);
    check("miss_ce",   32'(ceA),   32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick;
      check("miss_nvalid", 32'(validA), 32'd0);
    end
    tick;
    check("miss_valid", 32'(validA), 32'd1);
    check("miss_rdata", 32'(rdataA), 32'h77);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
